// File: rtl/ibex_multdiv_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_multdiv_arb_pkg
// Description : Shared types and constants for the two-port multdiv arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_multdiv_arb_pkg;

    localparam int NPORT           = 2;
    localparam int TIMEOUT_DEFAULT = 48;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [1:0]  oper;
        logic [1:0]  signed_mode;
        logic        is_div;
    } md_req_t;

    // Pull one port's slice out of the packed {port1, port0} request buses.
    function automatic md_req_t sel_req(
        input logic [63:0] op_a,
        input logic [63:0] op_b,
        input logic [3:0]  oper,
        input logic [3:0]  signed_mode,
        input logic [1:0]  is_div,
        input logic        idx
    );
        md_req_t r;
        r.op_a        = idx ? op_a[63:32]       : op_a[31:0];
        r.op_b        = idx ? op_b[63:32]       : op_b[31:0];
        r.oper        = idx ? oper[3:2]         : oper[1:0];
        r.signed_mode = idx ? signed_mode[3:2]  : signed_mode[1:0];
        r.is_div      = idx ? is_div[1]         : is_div[0];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_multdiv_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : ibex_multdiv_arb_if
// Description : Requester and multdiv-unit signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ibex_multdiv_arb_if;

    logic [1:0]  req_i;
    logic [1:0]  gnt_o;
    logic [63:0] op_a_i;
    logic [63:0] op_b_i;
    logic [3:0]  operator_i;
    logic [3:0]  signed_mode_i;
    logic [1:0]  is_div_i;
    logic [1:0]  rsp_valid_o;
    logic [1:0]  rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic        rsp_err_o;
    logic        md_mult_en_o;
    logic        md_div_en_o;
    logic [31:0] md_op_a_o;
    logic [31:0] md_op_b_o;
    logic [1:0]  md_operator_o;
    logic [1:0]  md_signed_mode_o;
    logic        md_valid_i;
    logic [31:0] md_result_i;

    modport slave (
        input  req_i, op_a_i, op_b_i, operator_i, signed_mode_i, is_div_i,
        input  rsp_ready_i, md_valid_i, md_result_i,
        output gnt_o, rsp_valid_o, rsp_result_o, rsp_err_o,
        output md_mult_en_o, md_div_en_o, md_op_a_o, md_op_b_o,
        output md_operator_o, md_signed_mode_o
    );

    modport master (
        output req_i, op_a_i, op_b_i, operator_i, signed_mode_i, is_div_i,
        output rsp_ready_i, md_valid_i, md_result_i,
        input  gnt_o, rsp_valid_o, rsp_result_o, rsp_err_o,
        input  md_mult_en_o, md_div_en_o, md_op_a_o, md_op_b_o,
        input  md_operator_o, md_signed_mode_o
    );

endinterface
`default_nettype wire

// File: rtl/ibex_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : ibex_rr_arb2
// Description : Two-way round-robin grant with a favoured-port pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    input  logic       upd_i,
    input  logic       served_i,
    output logic [1:0] gnt_o,
    output logic       idx_o
);

    logic ptr_q;

    always_comb begin
        gnt_o = 2'b00;
        idx_o = 1'b0;
        if (en_i) begin
            if (req_i[0] && (!req_i[1] || !ptr_q)) begin
                gnt_o = 2'b01;
                idx_o = 1'b0;
            end else if (req_i[1]) begin
                gnt_o = 2'b10;
                idx_o = 1'b1;
            end
        end
    end

    // The pointer names the favoured port: the one not served last.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else if (upd_i) begin
            ptr_q <= ~served_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ibex_multdiv_arb.sv
`default_nettype none
// ============================================================================
// Module      : ibex_multdiv_arb
// Description : Shares one multdiv unit between two requesters with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_multdiv_arb
    import ibex_multdiv_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int NPORT   = ibex_multdiv_arb_pkg::NPORT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ibex_multdiv_arb_if.slave bus
);

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q;
    md_req_t          req_q;
    logic             owner_q;
    logic             hold_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      result_q;
    logic             err_q;

    logic [1:0]       w_gnt;
    logic             w_idx;
    logic             w_grant_en;
    logic             w_hs;
    md_req_t          w_sel;
    logic [NPORT-1:0] w_rsp_valid;

    // hold_q blocks granting in the first IDLE cycle after a handshake.
    assign w_grant_en = (state_q == ST_IDLE) && !hold_q && !rst_i;
    assign w_hs       = (state_q == ST_RESP) && bus.rsp_ready_i[owner_q];

    ibex_rr_arb2 u_rr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (bus.req_i),
        .en_i     (w_grant_en),
        .upd_i    (w_hs),
        .served_i (owner_q),
        .gnt_o    (w_gnt),
        .idx_o    (w_idx)
    );

    assign w_sel = sel_req(bus.op_a_i, bus.op_b_i, bus.operator_i,
                           bus.signed_mode_i, bus.is_div_i, w_idx);

    always_comb begin
        w_rsp_valid = '0;
        if (state_q == ST_RESP) begin
            w_rsp_valid[owner_q] = 1'b1;
        end
    end

    assign bus.gnt_o            = w_gnt;
    assign bus.rsp_valid_o      = w_rsp_valid;
    assign bus.rsp_result_o     = result_q;
    assign bus.rsp_err_o        = err_q;
    assign bus.md_mult_en_o     = (state_q == ST_BUSY) && !req_q.is_div;
    assign bus.md_div_en_o      = (state_q == ST_BUSY) &&  req_q.is_div;
    assign bus.md_op_a_o        = req_q.op_a;
    assign bus.md_op_b_o        = req_q.op_b;
    assign bus.md_operator_o    = req_q.oper;
    assign bus.md_signed_mode_o = req_q.signed_mode;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            owner_q  <= 1'b0;
            hold_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    hold_q <= 1'b0;
                    if (|w_gnt) begin
                        req_q   <= w_sel;
                        owner_q <= w_idx;
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // A completion in the timeout cycle still counts as success.
                    if (bus.md_valid_i) begin
                        result_q <= bus.md_result_i;
                        err_q    <= 1'b0;
                        state_q  <= ST_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        state_q  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_hs) begin
                        err_q   <= 1'b0;
                        hold_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ibex_multdiv_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_multdiv_arb
// Description : Directed self-checking bench for ibex_multdiv_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_multdiv_arb;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    ibex_multdiv_arb_if bus();

    ibex_multdiv_arb #(
        .TIMEOUT (48),
        .NPORT   (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] opr, input logic [1:0] sm, input logic dv);
        bus.op_a_i[p*32 +: 32]      = a;
        bus.op_b_i[p*32 +: 32]      = b;
        bus.operator_i[p*2 +: 2]    = opr;
        bus.signed_mode_i[p*2 +: 2] = sm;
        bus.is_div_i[p]             = dv;
    endtask

    // Behaves as the multdiv unit: raises md_valid in the n-th BUSY cycle (never if n==0).
    task automatic unit_run(input int n, input logic [31:0] res,
                            output int em, output int ed, output int lat);
        em = 0; ed = 0; lat = 0;
        for (int k = 1; k <= 100; k++) begin
            if (bus.rsp_valid_o != 2'b00) begin
                lat = k;
                break;
            end
            if (bus.md_mult_en_o) em++;
            if (bus.md_div_en_o)  ed++;
            if (k == n) begin
                bus.md_valid_i  = 1'b1;
                bus.md_result_i = res;
            end
            tick();
            bus.md_valid_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_i = 2'b11;
        tick(); tick();
        checks++; if (bus.gnt_o !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b want 00", bus.gnt_o); end
        checks++; if (bus.rsp_valid_o !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid_o); end
        checks++; if ({bus.md_mult_en_o, bus.md_div_en_o} !== 2'b00) begin failures++; $display("FAIL reset_en: got %b want 00", {bus.md_mult_en_o, bus.md_div_en_o}); end
        checks++; if ({bus.rsp_result_o, bus.rsp_err_o} !== 33'd0) begin failures++; $display("FAIL reset_rsp: got %h/%b want 0/0", bus.rsp_result_o, bus.rsp_err_o); end
        checks++; if ({bus.md_op_a_o, bus.md_op_b_o, bus.md_operator_o, bus.md_signed_mode_o} !== 68'd0) begin failures++; $display("FAIL reset_md_regs: got %h %h %b %b want 0", bus.md_op_a_o, bus.md_op_b_o, bus.md_operator_o, bus.md_signed_mode_o); end
        bus.req_i = 2'b00;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mult_port0();
        int em, ed, lat;
        set_port(0, 32'd3, 32'd5, 2'd1, 2'd2, 1'b0);
        bus.req_i = 2'b01;
        #1;
        checks++; if (bus.gnt_o !== 2'b01) begin failures++; $display("FAIL mult_gnt: got %b want 01", bus.gnt_o); end
        tick();
        bus.req_i = 2'b00;
        checks++; if (bus.gnt_o !== 2'b00) begin failures++; $display("FAIL mult_gnt_pulse: got %b want 00", bus.gnt_o); end
        checks++; if ({bus.md_op_a_o, bus.md_op_b_o, bus.md_operator_o, bus.md_signed_mode_o} !== {32'd3, 32'd5, 2'd1, 2'd2}) begin
            failures++; $display("FAIL mult_md_ops: got %0d %0d %0d %0d want 3 5 1 2", bus.md_op_a_o, bus.md_op_b_o, bus.md_operator_o, bus.md_signed_mode_o);
        end
        unit_run(33, 32'd15, em, ed, lat);
        checks++; if (em != 33 || ed != 0) begin failures++; $display("FAIL mult_en_cycles: got mult=%0d div=%0d want 33 0", em, ed); end
        checks++; if (lat != 34) begin failures++; $display("FAIL mult_latency: got %0d want 34", lat); end
        checks++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_result_o !== 32'd15 || bus.rsp_err_o !== 1'b0) begin
            failures++; $display("FAIL mult_rsp: got v=%b r=%0d e=%b want 01 15 0", bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_err_o);
        end
        checks++; if ({bus.md_mult_en_o, bus.md_div_en_o} !== 2'b00) begin failures++; $display("FAIL mult_resp_en: got %b want 00", {bus.md_mult_en_o, bus.md_div_en_o}); end
        bus.rsp_ready_i = 2'b01;
        tick();
        bus.rsp_ready_i = 2'b00;
        checks++; if (bus.rsp_valid_o !== 2'b00) begin failures++; $display("FAIL mult_rsp_drop: got %b want 00", bus.rsp_valid_o); end
        tick();
    endtask

    task automatic test_both_request_div();
        int em, ed, lat;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        set_port(0, 32'd7, 32'd6, 2'd0, 2'd0, 1'b0);
        set_port(1, 32'd100, 32'd7, 2'd2, 2'd3, 1'b1);
        bus.req_i = 2'b11;
        #1;
        checks++; if (bus.gnt_o !== 2'b01) begin failures++; $display("FAIL both_first_gnt: got %b want 01", bus.gnt_o); end
        tick();
        bus.req_i = 2'b10;
        unit_run(4, 32'd42, em, ed, lat);
        checks++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_result_o !== 32'd42) begin
            failures++; $display("FAIL both_p0_rsp: got v=%b r=%0d want 01 42", bus.rsp_valid_o, bus.rsp_result_o);
        end
        checks++; if (bus.gnt_o !== 2'b00) begin failures++; $display("FAIL both_gnt_in_resp: got %b want 00", bus.gnt_o); end
        bus.rsp_ready_i = 2'b01;
        tick();
        bus.rsp_ready_i = 2'b00;
        checks++; if (bus.gnt_o !== 2'b00) begin failures++; $display("FAIL both_idle_gap: got %b want 00", bus.gnt_o); end
        tick();
        checks++; if (bus.gnt_o !== 2'b10) begin failures++; $display("FAIL both_second_gnt: got %b want 10", bus.gnt_o); end
        tick();
        bus.req_i = 2'b00;
        checks++; if ({bus.md_op_a_o, bus.md_op_b_o, bus.md_operator_o, bus.md_signed_mode_o} !== {32'd100, 32'd7, 2'd2, 2'd3}) begin
            failures++; $display("FAIL div_md_ops: got %0d %0d %0d %0d want 100 7 2 3", bus.md_op_a_o, bus.md_op_b_o, bus.md_operator_o, bus.md_signed_mode_o);
        end
        unit_run(6, 32'd14, em, ed, lat);
        checks++; if (em != 0 || ed != 6 || lat != 7) begin failures++; $display("FAIL div_en_cycles: got mult=%0d div=%0d lat=%0d want 0 6 7", em, ed, lat); end
        checks++; if (bus.rsp_valid_o !== 2'b10 || bus.rsp_result_o !== 32'd14 || bus.rsp_err_o !== 1'b0) begin
            failures++; $display("FAIL div_rsp: got v=%b r=%0d e=%b want 10 14 0", bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_err_o);
        end
        bus.rsp_ready_i = 2'b10;
        tick();
        bus.rsp_ready_i = 2'b00;
        tick();
    endtask

    task automatic test_resp_stall();
        int em, ed, lat;
        int bad;
        set_port(0, 32'd9, 32'd9, 2'd0, 2'd0, 1'b0);
        set_port(1, 32'd1, 32'd5, 2'd0, 2'd0, 1'b0);
        bus.req_i = 2'b01;
        #1;
        checks++; if (bus.gnt_o !== 2'b01) begin failures++; $display("FAIL stall_gnt: got %b want 01", bus.gnt_o); end
        tick();
        bus.req_i = 2'b10;
        unit_run(3, 32'd81, em, ed, lat);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            bus.rsp_ready_i = 2'b10;
            bus.md_valid_i  = 1'b1;
            bus.md_result_i = 32'd999;
            #1;
            checks++;
            if (bus.rsp_valid_o !== 2'b01 || bus.rsp_result_o !== 32'd81 || bus.gnt_o !== 2'b00 || bus.rsp_err_o !== 1'b0) begin
                failures++; bad++;
                $display("FAIL stall_hold: cycle %0d got v=%b r=%0d g=%b e=%b want 01 81 00 0", c, bus.rsp_valid_o, bus.rsp_result_o, bus.gnt_o, bus.rsp_err_o);
            end
            tick();
        end
        bus.md_valid_i  = 1'b0;
        bus.rsp_ready_i = 2'b01;
        tick();
        bus.rsp_ready_i = 2'b00;
        checks++; if (bus.gnt_o !== 2'b00) begin failures++; $display("FAIL stall_idle_gap: got %b want 00", bus.gnt_o); end
        tick();
        checks++; if (bus.gnt_o !== 2'b10) begin failures++; $display("FAIL stall_p1_gnt: got %b want 10", bus.gnt_o); end
        tick();
        bus.req_i = 2'b00;
        unit_run(2, 32'd5, em, ed, lat);
        checks++; if (bus.rsp_valid_o !== 2'b10 || bus.rsp_result_o !== 32'd5) begin
            failures++; $display("FAIL stall_p1_rsp: got v=%b r=%0d want 10 5", bus.rsp_valid_o, bus.rsp_result_o);
        end
        bus.rsp_ready_i = 2'b10;
        tick();
        bus.rsp_ready_i = 2'b00;
        tick();
    endtask

    task automatic test_timeout();
        int em, ed, lat;
        set_port(0, 32'd11, 32'd13, 2'd0, 2'd0, 1'b0);
        bus.req_i = 2'b01;
        #1;
        checks++; if (bus.gnt_o !== 2'b01) begin failures++; $display("FAIL to_gnt: got %b want 01", bus.gnt_o); end
        tick();
        bus.req_i = 2'b00;
        unit_run(0, 32'd0, em, ed, lat);
        checks++; if (em != 48 || lat != 49) begin failures++; $display("FAIL to_cycles: got en=%0d lat=%0d want 48 49", em, lat); end
        checks++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_err_o !== 1'b1 || bus.rsp_result_o !== 32'd0) begin
            failures++; $display("FAIL to_rsp: got v=%b e=%b r=%0d want 01 1 0", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_result_o);
        end
        checks++; if ({bus.md_mult_en_o, bus.md_div_en_o} !== 2'b00) begin failures++; $display("FAIL to_en_drop: got %b want 00", {bus.md_mult_en_o, bus.md_div_en_o}); end
        bus.rsp_ready_i = 2'b01;
        tick();
        bus.rsp_ready_i = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        set_port(0, 32'd21, 32'd2, 2'd1, 2'd1, 1'b0);
        set_port(1, 32'd4, 32'd4, 2'd0, 2'd0, 1'b0);
        bus.req_i = 2'b01;
        #1;
        checks++; if (bus.gnt_o !== 2'b01) begin failures++; $display("FAIL rmb_gnt: got %b want 01", bus.gnt_o); end
        tick();
        bus.req_i = 2'b00;
        for (int c = 1; c < 10; c++) tick();
        checks++; if (bus.md_mult_en_o !== 1'b1) begin failures++; $display("FAIL rmb_busy: got %b want 1", bus.md_mult_en_o); end
        #2;
        bus.req_i = 2'b11;
        rst = 1'b1;
        #1;
        checks++; if ({bus.md_mult_en_o, bus.md_div_en_o, bus.gnt_o, bus.rsp_valid_o, bus.rsp_err_o} !== 7'd0) begin
            failures++; $display("FAIL rmb_outputs: got en=%b%b g=%b v=%b e=%b want all 0", bus.md_mult_en_o, bus.md_div_en_o, bus.gnt_o, bus.rsp_valid_o, bus.rsp_err_o);
        end
        checks++; if ({bus.md_op_a_o, bus.md_op_b_o, bus.md_operator_o, bus.md_signed_mode_o, bus.rsp_result_o} !== 100'd0) begin
            failures++; $display("FAIL rmb_regs: got a=%0d b=%0d o=%b s=%b r=%0d want 0", bus.md_op_a_o, bus.md_op_b_o, bus.md_operator_o, bus.md_signed_mode_o, bus.rsp_result_o);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.gnt_o !== 2'b01) begin failures++; $display("FAIL rmb_favour_p0: got %b want 01", bus.gnt_o); end
        checks++; if (bus.rsp_valid_o !== 2'b00) begin failures++; $display("FAIL rmb_no_rsp: got %b want 00", bus.rsp_valid_o); end
        bus.req_i = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst             = 1'b0;
        bus.req_i       = 2'b00;
        bus.op_a_i      = '0;
        bus.op_b_i      = '0;
        bus.operator_i  = '0;
        bus.signed_mode_i = '0;
        bus.is_div_i    = '0;
        bus.rsp_ready_i = 2'b00;
        bus.md_valid_i  = 1'b0;
        bus.md_result_i = '0;
        #1;
        test_reset();
        test_mult_port0();
        test_both_request_div();
        test_resp_stall();
        test_timeout();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ibex_multdiv_arb.md
IBEX_MULTDIV_ARB -- requirements
Module: ibex_multdiv_arb

Interface
REQ-001 Parameter TIMEOUT, default 48: maximum BUSY cycles allowed before abort.
REQ-002 Parameter NPORT, default 2: number of requesters; fixed at 2 in this revision.
REQ-003 Port clk_i, input, 1: single clock, rising edge.
REQ-004 Port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 Port req_i, input, 2: per-port request; held until granted.
REQ-006 Port gnt_o, output, 2: one-hot, single-cycle accept pulse.
REQ-007 Port op_a_i, input, 64: {port1, port0} 32-bit operand A.
REQ-008 Port op_b_i, input, 64: {port1, port0} 32-bit operand B.
REQ-009 Port operator_i, input, 4: {port1, port0} 2-bit multdiv operator.
REQ-010 Port signed_mode_i, input, 4: {port1, port0} 2-bit signed mode.
REQ-011 Port is_div_i, input, 2: per port; 1 = divide/remainder, 0 = multiply.
REQ-012 Port rsp_valid_o, output, 2: one-hot response valid.
REQ-013 Port rsp_ready_i, input, 2: per-port response accept.
REQ-014 Port rsp_result_o, output, 32: shared response data.
REQ-015 Port rsp_err_o, output, 1: response is a timeout abort.
REQ-016 Ports md_mult_en_o and md_div_en_o, output, 1 each: enables to the multdiv unit.
REQ-017 Ports md_op_a_o and md_op_b_o, output, 32 each: operands to the unit.
REQ-018 Ports md_operator_o and md_signed_mode_o, output, 2 each: operator and signed mode to the unit.
REQ-019 Ports md_valid_i (input, 1) and md_result_i (input, 32): unit completion and result.

Function
REQ-020 States SHALL be IDLE, BUSY and RESP.
REQ-021 IDLE: if any req_i bit is set, grant one port, pulse gnt_o for that port, register its operands, operator, signed mode and is_div plus the owner index, then go to BUSY.
REQ-022 Arbitration is round-robin: on simultaneous requests the port not served last wins; the pointer resets to favour port0 and toggles only on completed handshakes.
REQ-023 gnt_o SHALL be zero outside IDLE; requests arriving in BUSY or RESP wait.
REQ-024 BUSY: assert exactly one of md_mult_en_o or md_div_en_o, chosen by the registered is_div; drive md_* from the registered copies, stable for the whole operation; never assert both enables.
REQ-025 BUSY: a cycle counter starts at 0 on entry and increments each cycle.
REQ-026 BUSY + md_valid_i: capture md_result_i, clear the error flag, go to RESP.
REQ-027 BUSY with counter == TIMEOUT-1 and no md_valid_i: set result 0 and rsp_err_o = 1, go to RESP.
REQ-028 If md_valid_i and timeout coincide, valid wins.
REQ-029 RESP: both enables low; the unit sees enable drop and clears its own state.
REQ-030 RESP: rsp_valid_o[owner] = 1; rsp_result_o and rsp_err_o stay stable until rsp_ready_i[owner].
REQ-031 RESP: rsp_ready_i of the non-owner is ignored.
REQ-032 Owner handshake moves the block to IDLE and updates the RR pointer; a new grant occurs no earlier than the following cycle.
REQ-033 Latency from grant to rsp_valid_o = unit cycles + 1; minimum issue interval = unit cycles + 3.
REQ-034 md_valid_i outside BUSY SHALL be ignored.

Reset
REQ-035 Asserting rst_i SHALL immediately (asynchronously) force state IDLE and set gnt_o, rsp_valid_o, rsp_err_o, md enables, counter, RR pointer, rsp_result_o and md_* operand/operator/mode registers all to 0.
REQ-036 Reset mid-BUSY or mid-RESP SHALL abort the operation with no response; requesters re-request.

Structure
REQ-037 Package ibex_multdiv_arb_pkg SHALL hold the state enum, NPORT and the default TIMEOUT constant.
REQ-038 Sub-module ibex_rr_arb2 SHALL contain the 2-way round-robin grant logic and its pointer.

Verification
REQ-039 Port0 multiply, op_a 3, op_b 5, model valid after 33 cycles with result 15 -> gnt_o = 01 for one cycle; md_mult_en_o high 33 cycles; rsp_valid_o = 01; rsp_result_o = 15; rsp_err_o = 0.
REQ-040 Both ports request on the same cycle after reset -> port0 granted first, port1 granted after the port0 handshake plus one IDLE cycle.
REQ-041 Port1 divide, is_div 1, op_a 100, op_b 7, model result 14 -> only md_div_en_o asserted; rsp_valid_o = 10 with result 14.
REQ-042 rsp_ready_i held low 5 cycles in RESP with port1 requesting -> rsp_valid_o and result stable; gnt_o stays 0 until after the handshake.
REQ-043 Model never asserts valid -> after 48 BUSY cycles, rsp_err_o = 1 and rsp_result_o = 0; enables drop.
REQ-044 rst_i asserted at BUSY cycle 10 -> enables and all outputs 0 the same cycle; after release, port0 is favoured.
